// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion controller: move directions,
// controller FSM states and default playfield geometry.
// Optional build macro: SPRITE_WRAP_EN (wrap moves instead of clamping).
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int unsigned DEF_STEP     = 32;
  localparam int unsigned DEF_SPR_SIZE = 32;
  localparam int unsigned DEF_X_MAX    = 640;
  localparam int unsigned DEF_Y_MAX    = 480;
  localparam int unsigned DEF_X_ORIGIN = 32;
  localparam int unsigned DEF_Y_ORIGIN = 146;

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational single-axis step: moves a coordinate by STEP toward 0 (dec=1)
// or toward MAX (dec=0), keeping the sprite inside the playfield.
// Build macro SPRITE_WRAP_EN: wrap modulo MAX instead of clamping; clamped is then 0.
module sprite_axis_step #(
  parameter int unsigned W        = 10,
  parameter int unsigned STEP     = 32,
  parameter int unsigned MAX      = 640,
  parameter int unsigned SPR_SIZE = 32
) (
  input  logic [W-1:0] coord,
  input  logic         dec,
  output logic [W-1:0] result,
  output logic         clamped
);

  localparam logic [W:0] STEP_E = (W+1)'(STEP);
`ifdef SPRITE_WRAP_EN
  localparam logic [W:0] MAX_E  = (W+1)'(MAX);
`else
  localparam logic [W:0] LIM_E  = (W+1)'(MAX - SPR_SIZE);
`endif

  logic [W:0] ext;
  logic [W:0] sum;

  // Step arithmetic carried in one extra bit so the overflow tests are exact
  always_comb begin
    ext     = {1'b0, coord};
    sum     = ext + STEP_E;
    result  = W'(sum);
    clamped = 1'b0;
`ifdef SPRITE_WRAP_EN
    if (dec) begin
      result = (ext < STEP_E) ? W'(ext + MAX_E - STEP_E) : W'(ext - STEP_E);
    end else begin
      result = (sum >= MAX_E) ? W'(sum - MAX_E) : W'(sum);
    end
`else
    if (dec) begin
      if (ext < STEP_E) begin
        result  = '0;
        clamped = 1'b1;
      end else begin
        result = W'(ext - STEP_E);
      end
    end else if (sum > LIM_E) begin
      result  = W'(LIM_E);
      clamped = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Multi-sprite position controller. Move commands are buffered per sprite
// (last one wins) and applied one sprite per cycle after a frame tick, then
// overlap with sprite 0 is evaluated.
// Build macro SPRITE_WRAP_EN: moves wrap around the playfield, blocked stays 0.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 9,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned SPR_SIZE    = DEF_SPR_SIZE,
  parameter int unsigned X_MAX       = DEF_X_MAX,
  parameter int unsigned Y_MAX       = DEF_Y_MAX,
  parameter int unsigned X_ORIGIN    = DEF_X_ORIGIN,
  parameter int unsigned Y_ORIGIN    = DEF_Y_ORIGIN,
  localparam int unsigned ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ID_W-1:0]            cmd_id,
  input  logic [1:0]                 cmd_dir,
  output logic [NUM_SPRITES*X_W-1:0] pos_x,
  output logic [NUM_SPRITES*Y_W-1:0] pos_y,
  output logic [NUM_SPRITES-1:0]     hit,
  output logic                       hit_pulse,
  output logic                       blocked
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_SPRITES - 1);
  localparam logic [X_W-1:0]  SZ_X     = X_W'(SPR_SIZE);
  localparam logic [Y_W-1:0]  SZ_Y     = Y_W'(SPR_SIZE);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        idx_q, idx_d;
  logic [NUM_SPRITES-1:0] pend_q, pend_d;
  logic [1:0]             dir_q [NUM_SPRITES];
  logic [1:0]             dir_d [NUM_SPRITES];
  logic [X_W-1:0]         px_q  [NUM_SPRITES];
  logic [X_W-1:0]         px_d  [NUM_SPRITES];
  logic [Y_W-1:0]         py_q  [NUM_SPRITES];
  logic [Y_W-1:0]         py_d  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit_q, hit_d;
  logic                   hit_pulse_q, hit_pulse_d;
  logic                   blocked_q, blocked_d;
  logic                   cmd_ready_q, cmd_ready_d;

  logic [1:0]             cur_dir;
  logic                   horiz;
  logic [X_W-1:0]         nxt_x;
  logic [Y_W-1:0]         nxt_y;
  logic                   x_cl, y_cl;
  logic [NUM_SPRITES-1:0] overlap;

  assign cur_dir = dir_q[idx_q];
  assign horiz   = (cur_dir == DIR_LEFT) || (cur_dir == DIR_RIGHT);

  sprite_axis_step #(.W(X_W), .STEP(STEP), .MAX(X_MAX), .SPR_SIZE(SPR_SIZE)) u_step_x (
    .coord   (px_q[idx_q]),
    .dec     (cur_dir == DIR_LEFT),
    .result  (nxt_x),
    .clamped (x_cl)
  );

  sprite_axis_step #(.W(Y_W), .STEP(STEP), .MAX(Y_MAX), .SPR_SIZE(SPR_SIZE)) u_step_y (
    .coord   (py_q[idx_q]),
    .dec     (cur_dir == DIR_UP),
    .result  (nxt_y),
    .clamped (y_cl)
  );

  // Overlap of every sprite with the player, by unsigned absolute distance
  always_comb begin
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    overlap = '0;
    dx      = '0;
    dy      = '0;
    for (int unsigned i = 1; i < NUM_SPRITES; i++) begin
      dx = (px_q[i] >= px_q[0]) ? px_q[i] - px_q[0] : px_q[0] - px_q[i];
      dy = (py_q[i] >= py_q[0]) ? py_q[i] - py_q[0] : py_q[0] - py_q[i];
      overlap[i] = (dx < SZ_X) && (dy < SZ_Y);
    end
  end

  // Controller next state: buffer commands in IDLE, walk sprites in APPLY, compare in CHECK
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    dir_d       = dir_q;
    px_d        = px_q;
    py_d        = py_q;
    hit_d       = hit_q;
    hit_pulse_d = 1'b0;
    blocked_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pend_d[cmd_id] = 1'b1;
          dir_d[cmd_id]  = cmd_dir;
        end
        if (frame_tick) begin
          state_d = ST_APPLY;
          idx_d   = '0;
        end
      end
      ST_APPLY: begin
        if (pend_q[idx_q]) begin
          pend_d[idx_q] = 1'b0;
          if (horiz) begin
            px_d[idx_q] = nxt_x;
            blocked_d   = x_cl;
          end else begin
            py_d[idx_q] = nxt_y;
            blocked_d   = y_cl;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_CHECK;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_CHECK: begin
        hit_d       = overlap;
        hit_pulse_d = |(overlap & ~hit_q);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset to the start layout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pend_q      <= '0;
      hit_q       <= '0;
      hit_pulse_q <= 1'b0;
      blocked_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        dir_q[i] <= DIR_LEFT;
        px_q[i]  <= X_W'(X_ORIGIN + 2 * SPR_SIZE * i);
        py_q[i]  <= Y_W'(Y_ORIGIN);
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      px_q        <= px_d;
      py_q        <= py_d;
      hit_q       <= hit_d;
      hit_pulse_q <= hit_pulse_d;
      blocked_q   <= blocked_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Pack per-sprite registers onto the flat output buses
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      pos_x[i*X_W +: X_W] = px_q[i];
      pos_y[i*Y_W +: Y_W] = py_q[i];
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign hit       = hit_q;
  assign hit_pulse = hit_pulse_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: a frame-level reference model
// predicts every output each cycle, plus hand-computed literal expectations.
// Honours SPRITE_WRAP_EN the same way as the design build.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_id = '0;
  logic [1:0]      cmd_dir = '0;
  logic            cmd_ready;
  logic [N*XW-1:0] pos_x;
  logic [N*YW-1:0] pos_y;
  logic [N-1:0]    hit;
  logic            hit_pulse;
  logic            blocked;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.NUM_SPRITES(N), .X_W(XW), .Y_W(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_dir    (cmd_dir),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .hit        (hit),
    .hit_pulse  (hit_pulse),
    .blocked    (blocked)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gx(input int i);
    return int'(pos_x[i*XW +: XW]);
  endfunction

  function automatic int gy(input int i);
    return int'(pos_y[i*YW +: YW]);
  endfunction

  // ---------------- frame-level reference model ----------------
  int       c = 0;
  int       frame_t = -1;
  int       cx[N], cy[N], nx[N], ny[N];
  bit       ncl[N];
  bit [N-1:0] chit, nhit;
  bit       pend[N];
  int       pdir[N];
  int       ex[N], ey[N];
  bit       e_ready, e_blocked, e_pulse;
  bit [N-1:0] e_hit;
  bit       model_ok = 1'b0;

  function automatic int mstep(input int v, input bit dec, input int mx, output bit cl);
    cl = 1'b0;
`ifdef SPRITE_WRAP_EN
    if (dec) return (v < 32) ? v + mx - 32 : v - 32;
    return (v + 32 >= mx) ? v + 32 - mx : v + 32;
`else
    if (dec) begin
      if (v < 32) begin
        cl = 1'b1;
        return 0;
      end
      return v - 32;
    end
    if (v + 32 > mx - 32) begin
      cl = 1'b1;
      return mx - 32;
    end
    return v + 32;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      cx[i] = 32 + 64 * i;
      cy[i] = 146;
      nx[i] = cx[i];
      ny[i] = cy[i];
      ncl[i] = 1'b0;
      pend[i] = 1'b0;
      pdir[i] = 0;
    end
    chit = '0;
    nhit = '0;
    frame_t = -1;
  endtask

  task automatic model_frame();
    bit cl;
    int dx, dy;
    cx = nx;
    cy = ny;
    chit = nhit;
    for (int i = 0; i < N; i++) begin
      ncl[i] = 1'b0;
      if (pend[i]) begin
        case (pdir[i])
          0: nx[i] = mstep(cx[i], 1'b1, 640, cl);
          1: nx[i] = mstep(cx[i], 1'b0, 640, cl);
          2: ny[i] = mstep(cy[i], 1'b1, 480, cl);
          default: ny[i] = mstep(cy[i], 1'b0, 480, cl);
        endcase
        ncl[i] = cl;
        pend[i] = 1'b0;
      end
    end
    nhit = '0;
    for (int i = 1; i < N; i++) begin
      dx = nx[i] - nx[0];
      dy = ny[i] - ny[0];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      nhit[i] = (dx < 32) && (dy < 32);
    end
  endtask

  // c counts edges; outputs after edge c are the values of cycle c, inputs seen belong to cycle c-1
  always @(posedge clk) begin
    bit busy;
    c++;
    if (rst) begin
      model_reset();
    end else begin
      busy = (frame_t >= 0) && (c - 1 >= frame_t + 1) && (c - 1 <= frame_t + 1 + N);
      if (!busy && cmd_valid) begin
        pend[cmd_id] = 1'b1;
        pdir[cmd_id] = int'(cmd_dir);
      end
      if (!busy && frame_tick) begin
        model_frame();
        frame_t = c - 1;
      end
    end
    e_ready   = !((frame_t >= 0) && (c >= frame_t + 1) && (c <= frame_t + 1 + N));
    e_blocked = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((frame_t >= 0) && (c >= frame_t + 2 + i)) begin
        ex[i] = nx[i];
        ey[i] = ny[i];
      end else begin
        ex[i] = cx[i];
        ey[i] = cy[i];
      end
      if ((frame_t >= 0) && (c == frame_t + 2 + i) && ncl[i]) e_blocked = 1'b1;
    end
    e_hit   = ((frame_t >= 0) && (c >= frame_t + 2 + N)) ? nhit : chit;
    e_pulse = (frame_t >= 0) && (c == frame_t + 2 + N) && (|(nhit & ~chit));
    model_ok = 1'b1;
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmd_ready", int'(cmd_ready), int'(e_ready));
      for (int i = 0; i < N; i++) begin
        chk($sformatf("pos_x[%0d]", i), gx(i), ex[i]);
        chk($sformatf("pos_y[%0d]", i), gy(i), ey[i]);
      end
      chk("hit", int'(hit), int'(e_hit));
      chk("hit_pulse", int'(hit_pulse), int'(e_pulse));
      chk("blocked", int'(blocked), int'(e_blocked));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmd(input int id, input int d);
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_id    = 2'(id);
    cmd_dir   = 2'(d);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  // Returns 2ns into cycle T+1, where T is the tick cycle
  task automatic tick();
    @(posedge clk); #2;
    frame_tick = 1'b1;
    @(posedge clk); #2;
    frame_tick = 1'b0;
  endtask

  task automatic settle();
    repeat (N + 3) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // reset layout
    @(negedge clk);
    chk("rst_x0", gx(0), 32);
    chk("rst_y0", gy(0), 146);
    chk("rst_x1", gx(1), 96);
    chk("rst_x3", gx(3), 224);
    chk("rst_hit", int'(hit), 0);
    chk("rst_ready", int'(cmd_ready), 1);

    // player right once
    cmd(0, 1);
    tick();
    settle();
    chk("right1_x0", gx(0), 64);
    chk("right1_hit", int'(hit), 0);

    // second right lands on sprite 1: pulse exactly at T+6
    cmd(0, 1);
    tick();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("pulse_T+%0d", k), int'(hit_pulse), (k == 6) ? 1 : 0);
    end
    settle();
    chk("right2_x0", gx(0), 96);
    chk("right2_hit", int'(hit), 2);

    // walk left to the edge: 96 -> 64 -> 32 -> 0
    for (int r = 0; r < 3; r++) begin
      cmd(0, 0);
      tick();
      settle();
    end
    chk("left_x0", gx(0), 0);
    chk("left_hit", int'(hit), 0);

    // one more left at the edge
    cmd(0, 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
`ifdef SPRITE_WRAP_EN
      chk($sformatf("edge_blocked_T+%0d", k), int'(blocked), 0);
`else
      chk($sformatf("edge_blocked_T+%0d", k), int'(blocked), (k == 2) ? 1 : 0);
`endif
    end
    settle();
`ifdef SPRITE_WRAP_EN
    chk("edge_x0", gx(0), 608);
`else
    chk("edge_x0", gx(0), 0);
`endif

    // last command wins for sprite 2
    cmd(2, 2);
    cmd(2, 3);
    tick();
    settle();
    chk("lastwin_y2", gy(2), 178);
    chk("lastwin_x2", gx(2), 160);
    chk("lastwin_y1", gy(1), 146);

    // command held through the busy window
    tick();
    cmd_valid = 1'b1;
    cmd_id    = 2'd1;
    cmd_dir   = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("busy_ready_T+%0d", k), int'(cmd_ready), (k == 6) ? 1 : 0);
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    settle();
    chk("held_x1_before", gx(1), 96);
    tick();
    settle();
    chk("held_x1_after", gx(1), 128);

    // reset in the middle of APPLY
    cmd(0, 1);
    cmd(3, 2);
    tick();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_x0", gx(0), 32);
    chk("midrst_x1", gx(1), 96);
    chk("midrst_y2", gy(2), 146);
    chk("midrst_y3", gy(3), 146);
    chk("midrst_ready", int'(cmd_ready), 1);
    tick();
    settle();
    chk("postrst_x0", gx(0), 32);
    chk("postrst_y3", gy(3), 146);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
